// File: rtl/mpc_pkg.sv
// Shared definitions for the mpc_io_mux pad multiplexer: register map,
// STATUS bit positions, handover FSM encoding and switch-counter width.
package mpc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_SWCNT  = 2'd2;

  localparam int CTRL_EN_BIT     = 31;
  localparam int STATUS_BUSY_BIT = 8;
  localparam int STATUS_ERR_BIT  = 31;

  localparam int SWCNT_W = 16;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } mpc_state_e;

endpackage

// File: rtl/mpc_wb_regs.sv
// Wishbone slave for mpc_io_mux: address decode, single-cycle ack, CTRL/STATUS
// storage and the optional switch counter (present when MPC_SWITCH_CNT_EN is defined).
module mpc_wb_regs
  import mpc_pkg::*;
#(
  parameter int          N_PROJ    = 4,
  parameter int          SEL_W     = $clog2(N_PROJ),
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [SEL_W-1:0] strap_sel,
  input  logic [SEL_W-1:0] cur_sel,
  input  logic             busy,
  input  logic             swcnt_inc,
  output logic [SEL_W-1:0] req_sel,
  output logic             enable
);

  logic             ack_reg;
  logic [31:0]      dat_reg;
  logic [SEL_W-1:0] req_sel_reg;
  logic             enable_reg;
  logic             err_reg;
  logic             hit;
  logic             access;
  logic             wr_en;
  logic             sel_valid;
  logic [31:0]      rd_data;

  assign hit       = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign access    = wbs_stb_i & wbs_cyc_i & ~ack_reg & hit;
  assign wr_en     = access & wbs_we_i;
  // The whole low byte is range-checked so out-of-range selects that alias
  // onto a valid code in SEL_W bits are still rejected.
  assign sel_valid = (wbs_dat_i[7:0] < 8'(N_PROJ));

`ifdef MPC_SWITCH_CNT_EN
  logic [SWCNT_W-1:0] swcnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      swcnt_reg <= '0;
    end else if (swcnt_inc && (swcnt_reg != '1)) begin
      swcnt_reg <= swcnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      REG_CTRL: begin
        rd_data[SEL_W-1:0]  = req_sel_reg;
        rd_data[CTRL_EN_BIT] = enable_reg;
      end
      REG_STATUS: begin
        rd_data[SEL_W-1:0]      = cur_sel;
        rd_data[STATUS_BUSY_BIT] = busy;
        rd_data[STATUS_ERR_BIT]  = err_reg;
      end
      REG_SWCNT: begin
`ifdef MPC_SWITCH_CNT_EN
        rd_data[SWCNT_W-1:0] = swcnt_reg;
`endif
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
      req_sel_reg <= strap_sel;
      enable_reg  <= 1'b1;
      err_reg     <= 1'b0;
    end else begin
      ack_reg <= access;
      dat_reg <= (access && !wbs_we_i) ? rd_data : '0;
      if (wr_en && (wbs_adr_i[3:2] == REG_STATUS)) begin
        err_reg <= 1'b0;
      end
      if (wr_en && (wbs_adr_i[3:2] == REG_CTRL)) begin
        if (wbs_sel_i[3]) begin
          enable_reg <= wbs_dat_i[CTRL_EN_BIT];
        end
        if (wbs_sel_i[0]) begin
          if (sel_valid) begin
            req_sel_reg <= wbs_dat_i[SEL_W-1:0];
          end else begin
            err_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;
  assign req_sel   = req_sel_reg;
  assign enable    = enable_reg;

`ifdef MPC_SWITCH_CNT_EN
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[2:1], wbs_adr_i[1:0], wbs_dat_i[30:8]};
`else
  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i[2:1], wbs_adr_i[1:0], wbs_dat_i[30:8], swcnt_inc};
`endif

endmodule

// File: rtl/mpc_io_mux.sv
// Wishbone-controlled pad multiplexer: N_PROJ projects share one IO_W pad bus,
// with a guarded tri-state handover on every switch. Optional SWCNT via MPC_SWITCH_CNT_EN.
module mpc_io_mux
  import mpc_pkg::*;
#(
  parameter int          N_PROJ    = 4,
  parameter int          IO_W      = 38,
  parameter int          SEL_W     = $clog2(N_PROJ),
  parameter int          GUARD     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [SEL_W-1:0]         configuration,
  input  logic [IO_W-1:0]          IO_i,
  output logic [IO_W-1:0]          IO_o,
  output logic [IO_W-1:0]          IO_oe,
  input  logic [N_PROJ*IO_W-1:0]   proj_o,
  input  logic [N_PROJ*IO_W-1:0]   proj_oe,
  output logic [N_PROJ*IO_W-1:0]   proj_i,
  output logic [N_PROJ-1:0]        proj_rst_o
);

  mpc_state_e       state_reg, state_next;
  logic [SEL_W-1:0] cur_sel_reg, cur_sel_next;
  logic [7:0]       drain_cnt_reg, drain_cnt_next;
  logic [SEL_W-1:0] strap_sel;
  logic [SEL_W-1:0] req_sel;
  logic             enable;
  logic             swcnt_inc;
  logic             busy;
  logic             pads_on;
  logic [IO_W-1:0]  io_o_reg, io_oe_reg;
  logic [IO_W-1:0]  proj_o_arr  [N_PROJ];
  logic [IO_W-1:0]  proj_oe_arr [N_PROJ];
  logic [IO_W-1:0]  proj_i_arr  [N_PROJ];
  logic             proj_rst_arr [N_PROJ];

  assign strap_sel = (32'(configuration) < N_PROJ) ? configuration : '0;
  assign busy      = (state_reg != ST_ACTIVE);
  assign pads_on   = (state_reg == ST_ACTIVE) && enable;

  mpc_wb_regs #(
    .N_PROJ    (N_PROJ),
    .SEL_W     (SEL_W),
    .ADDR_BASE (ADDR_BASE)
  ) u_regs (
    .clk       (wb_clk_i),
    .srst      (wb_rst_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .strap_sel (strap_sel),
    .cur_sel   (cur_sel_reg),
    .busy      (busy),
    .swcnt_inc (swcnt_inc),
    .req_sel   (req_sel),
    .enable    (enable)
  );

  // req_sel only moves on a valid CTRL write, so a level compare in ACTIVE also
  // catches writes that landed during the SWITCH cycle.
  always_comb begin
    state_next     = state_reg;
    cur_sel_next   = cur_sel_reg;
    drain_cnt_next = drain_cnt_reg;
    swcnt_inc      = 1'b0;
    case (state_reg)
      ST_ACTIVE: begin
        if (req_sel != cur_sel_reg) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg == 8'(GUARD - 1)) begin
          state_next = ST_SWITCH;
        end else begin
          drain_cnt_next = drain_cnt_reg + 8'd1;
        end
      end
      ST_SWITCH: begin
        cur_sel_next = req_sel;
        swcnt_inc    = (req_sel != cur_sel_reg);
        state_next   = ST_ACTIVE;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= ST_ACTIVE;
      cur_sel_reg   <= strap_sel;
      drain_cnt_reg <= '0;
      io_o_reg      <= '0;
      io_oe_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      cur_sel_reg   <= cur_sel_next;
      drain_cnt_reg <= drain_cnt_next;
      io_o_reg      <= pads_on ? proj_o_arr[cur_sel_reg]  : '0;
      io_oe_reg     <= pads_on ? proj_oe_arr[cur_sel_reg] : '0;
    end
  end

  for (genvar gi = 0; gi < N_PROJ; gi++) begin : g_proj
    assign proj_o_arr[gi]  = proj_o[gi*IO_W +: IO_W];
    assign proj_oe_arr[gi] = proj_oe[gi*IO_W +: IO_W];

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        proj_i_arr[gi]   <= '0;
        proj_rst_arr[gi] <= 1'b1;
      end else begin
        proj_i_arr[gi]   <= (cur_sel_reg == SEL_W'(gi)) ? IO_i : '0;
        proj_rst_arr[gi] <= !(pads_on && (cur_sel_reg == SEL_W'(gi)));
      end
    end

    assign proj_i[gi*IO_W +: IO_W] = proj_i_arr[gi];
    assign proj_rst_o[gi]          = proj_rst_arr[gi];
  end

  assign IO_o  = io_o_reg;
  assign IO_oe = io_oe_reg;

endmodule

// File: tb/tb_mpc_io_mux.sv
// Directed self-checking bench for mpc_io_mux (N_PROJ=4, IO_W=38, GUARD=4);
// SWCNT expectations follow MPC_SWITCH_CNT_EN.
module tb_mpc_io_mux;

  localparam int N_PROJ = 4;
  localparam int IO_W   = 38;
  localparam int SEL_W  = 2;
  localparam int GUARD  = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef MPC_SWITCH_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_adr_i, wbs_dat_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;
  logic [SEL_W-1:0]       configuration;
  logic [IO_W-1:0]        IO_i, IO_o, IO_oe;
  logic [N_PROJ*IO_W-1:0] proj_o, proj_oe, proj_i;
  logic [N_PROJ-1:0]      proj_rst_o;

  logic [IO_W-1:0] pat    [N_PROJ];
  logic [IO_W-1:0] oe_pat [N_PROJ];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpc_io_mux #(
    .N_PROJ(N_PROJ), .IO_W(IO_W), .SEL_W(SEL_W), .GUARD(GUARD), .ADDR_BASE(BASE)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(srst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .configuration(configuration),
    .IO_i(IO_i), .IO_o(IO_o), .IO_oe(IO_oe),
    .proj_o(proj_o), .proj_oe(proj_oe), .proj_i(proj_i),
    .proj_rst_o(proj_rst_o)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one Wishbone access starting now; gives up after 6 edges.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
    acked = 1'b0;
    rdata = '0;
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic ack;
    wb_access(adr, 1'b1, dat, sel, rd, ack);
    check("wr_ack", ack, 1'b1);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
    logic ack;
    wb_access(adr, 1'b0, 32'h0, 4'hF, rd, ack);
    check("rd_ack", ack, 1'b1);
  endtask

  function automatic logic [N_PROJ*IO_W-1:0] exp_pi(input int sel, input logic [IO_W-1:0] v);
    logic [N_PROJ*IO_W-1:0] r;
    r = '0;
    r[sel*IO_W +: IO_W] = v;
    return r;
  endfunction

  initial begin
    logic [31:0] rd;
    logic ack;
    int zeros;
    int seen3;

    for (int k = 0; k < N_PROJ; k++) begin
      pat[k]    = {6'(k + 1), 32'h1234_5670 + 32'(k)};
      oe_pat[k] = ~pat[k];
      proj_o[k*IO_W +: IO_W]  = pat[k];
      proj_oe[k*IO_W +: IO_W] = oe_pat[k];
    end
    IO_i = 38'h2A_DEAD_BEEF;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0;
    configuration = 2'd2;
    srst = 1'b1;

    // Reset values
    tick(3);
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_io_o", IO_o, 38'h0);
    check("rst_io_oe", IO_oe, 38'h0);
    check("rst_proj_i", proj_i, 152'h0);
    check("rst_proj_rst", proj_rst_o, 4'b1111);

    // Strap 2 comes up on the pads one cycle after release
    srst = 1'b0;
    tick(1);
    check("strap_io_o", IO_o, pat[2]);
    check("strap_io_oe", IO_oe, oe_pat[2]);
    check("strap_rst", proj_rst_o, 4'b1011);
    check("strap_proj_i", proj_i, exp_pi(2, IO_i));
    wb_read(BASE + 32'h4, rd);
    check("status_init", rd, 32'h0000_0002);
    wb_read(BASE + 32'h0, rd);
    check("ctrl_init", rd, 32'h8000_0002);
    tick(1);
    check("ack_drop", wbs_ack_o, 1'b0);

    // Switch to project 1: timing of the guarded handover
    wb_write(BASE, 32'h8000_0001, 4'hF);
    zeros = 0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 1) begin
        check("sw_t1_oe", IO_oe, oe_pat[2]);
        check("sw_t1_rst", proj_rst_o, 4'b1011);
      end
      if (i == 2) check("sw_t2_rst", proj_rst_o, 4'b1111);
      if (i == 6) check("sw_t6_oe", IO_oe, 38'h0);
      if (IO_oe == '0) zeros++;
    end
    check("sw_guard_len", zeros, 5);
    check("sw_t7_io_o", IO_o, pat[1]);
    check("sw_t7_oe", IO_oe, oe_pat[1]);
    check("sw_t7_rst", proj_rst_o, 4'b1101);
    wb_read(BASE + 32'h4, rd);
    check("status_sw1", rd, 32'h0000_0001);
    wb_read(BASE + 32'h8, rd);
    check("swcnt_1", rd, 32'(CNT_EN));

    // Out-of-range select sets err and changes nothing
    wb_write(BASE, 32'h8000_0005, 4'hF);
    tick(3);
    check("err_rst", proj_rst_o, 4'b1101);
    wb_read(BASE + 32'h4, rd);
    check("status_err", rd, 32'h8000_0001);
    wb_read(BASE, rd);
    check("ctrl_after_err", rd, 32'h8000_0001);
    wb_write(BASE + 32'h4, 32'h0, 4'hF);
    wb_read(BASE + 32'h4, rd);
    check("status_errclr", rd, 32'h0000_0001);

    // Two writes during DRAIN collapse into one switch to project 0
    wb_write(BASE, 32'h8000_0003, 4'hF);
    wb_write(BASE, 32'h8000_0000, 4'hF);
    seen3 = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (IO_oe == oe_pat[3]) seen3++;
    end
    check("no_proj3", seen3, 0);
    check("p0_io_o", IO_o, pat[0]);
    check("p0_rst", proj_rst_o, 4'b1110);
    check("p0_proj_i", proj_i, exp_pi(0, IO_i));
    wb_read(BASE + 32'h4, rd);
    check("status_p0", rd, 32'h0000_0000);
    wb_read(BASE + 32'h8, rd);
    check("swcnt_2", rd, 32'(2 * CNT_EN));

    // Disable via byte lane 3 only, then re-enable
    wb_write(BASE, 32'h0000_0003, 4'b1000);
    tick(2);
    check("dis_io_oe", IO_oe, 38'h0);
    check("dis_io_o", IO_o, 38'h0);
    check("dis_rst", proj_rst_o, 4'b1111);
    wb_read(BASE, rd);
    check("ctrl_dis", rd, 32'h0000_0000);
    wb_write(BASE, 32'h8000_0000, 4'hF);
    tick(2);
    check("en_io_oe", IO_oe, oe_pat[0]);
    check("en_rst", proj_rst_o, 4'b1110);

    // Undecoded address gets no ack; offset 3 reads zero
    wb_access(BASE + 32'h10, 1'b1, 32'h8000_0001, 4'hF, rd, ack);
    check("undec_noack", ack, 1'b0);
    wb_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    wb_read(BASE + 32'hC, rd);
    check("off3_zero", rd, 32'h0);
    wb_read(BASE, rd);
    check("ctrl_undec", rd, 32'h8000_0000);

    // Reset in the middle of DRAIN re-samples the strap
    wb_write(BASE, 32'h8000_0002, 4'hF);
    tick(2);
    check("mid_drain_rst", proj_rst_o, 4'b1111);
    configuration = 2'd3;
    srst = 1'b1;
    tick(1);
    check("abort_ack", wbs_ack_o, 1'b0);
    check("abort_oe", IO_oe, 38'h0);
    srst = 1'b0;
    tick(1);
    check("abort_rst", proj_rst_o, 4'b0111);
    check("abort_io_o", IO_o, pat[3]);
    wb_read(BASE + 32'h4, rd);
    check("status_abort", rd, 32'h0000_0003);
    wb_read(BASE + 32'h8, rd);
    check("swcnt_abort", rd, 32'h0);
    wb_read(BASE, rd);
    check("ctrl_abort", rd, 32'h8000_0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpc_io_mux.md
# mpc_io_mux

Parametrised, Wishbone-controlled pad multiplexer for the multi-project chip: generalises the fixed 2x2 pin-strap project selection to `N_PROJ` projects sharing one `IO_W`-bit pad bus. The active project is chosen at reset from strap pins and can be changed at run time over Wishbone. A guarded handover tri-states the pads and holds project resets for a programmable number of cycles during every switch. It sits between the user-project wrappers and the chip IO ring, on the management Wishbone bus.

## Interface
- `N_PROJ`, 4, number of projects (2..16)
- `IO_W`, 38, shared pad bus width
- `SEL_W`, $clog2(N_PROJ), select field width (derived)
- `GUARD`, 4, drain cycles during a switch (1..255)
- `ADDR_BASE`, 32'h3000_0000, Wishbone base; block decodes `wbs_adr_i[31:4] == ADDR_BASE[31:4]`

- `wb_clk_i` in 1: single clock
- `wb_rst_i` in 1: synchronous, active-high reset
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone classic strobe/cycle/write
- `wbs_sel_i` in 4: byte enables
- `wbs_adr_i`, `wbs_dat_i` in 32: address, write data
- `wbs_ack_o` out 1: acknowledge
- `wbs_dat_o` out 32: read data
- `configuration` in SEL_W: strap select, sampled only during reset
- `IO_i` in IO_W; `IO_o`, `IO_oe` out IO_W: pad side
- `proj_o`, `proj_oe` in N_PROJ*IO_W: per-project outputs, project k at slice [k*IO_W +: IO_W]
- `proj_i` out N_PROJ*IO_W: per-project pad inputs
- `proj_rst_o` out N_PROJ: per-project reset, active-high

## Operation
- Registers at offset `adr[3:2]`:
  - 0 CTRL: [SEL_W-1:0] req_sel, [31] enable. RW, byte-lane masked by `wbs_sel_i`.
  - 1 STATUS: [SEL_W-1:0] cur_sel, [8] busy, [31] err. RO; any write clears err.
  - 2 SWCNT: 16-bit completed-switch count, saturating at 16'hFFFF.
  - 3: reads 0, writes ignored.
- Wishbone: `stb&cyc&~ack` in a decoded range → `wbs_ack_o` high exactly one cycle later, low the following cycle; read data valid with ack. Undecoded addresses receive no ack.
- A CTRL write with req_sel ≥ N_PROJ sets err; CTRL.req_sel and the FSM are unchanged (enable bits still written).
- FSM:
  - ACTIVE → DRAIN when a valid req_sel ≠ cur_sel is written.
  - DRAIN counts GUARD cycles, then → SWITCH.
  - SWITCH (1 cycle): cur_sel ← latest req_sel, SWCNT+1, → ACTIVE.
  - CTRL writes during DRAIN update req_sel and do not restart the count.
  - If req_sel == cur_sel at SWITCH, no count increment.
- busy = (state ≠ ACTIVE).
- Pads: in ACTIVE with enable=1, `IO_o`/`IO_oe` ← slice cur_sel of `proj_o`/`proj_oe`. Otherwise `IO_o`=0 and `IO_oe`=0.
- `proj_i`: slice cur_sel ← `IO_i`; all other slices 0.
- `proj_rst_o[k]` = 1 unless (k == cur_sel && state == ACTIVE && enable).
- Reset values:
  - cur_sel = req_sel = `configuration`, or 0 if the strap ≥ N_PROJ
  - enable = 1, err = 0, SWCNT = 0, state ACTIVE
  - `wbs_ack_o` = 0, `wbs_dat_o` = 0, `IO_o` = 0, `IO_oe` = 0, `proj_i` = 0, `proj_rst_o` = all ones

## Timing
- `IO_o`/`IO_oe` and `proj_i` are registered: 1-cycle latency from source.
- `proj_rst_o` is registered and updates in the cycle after a state/enable change.
- Write ACKed in cycle T → DRAIN from T+1; pads 0 from T+2; SWITCH at T+1+GUARD; new project on pads at T+3+GUARD.
- Reset asserted mid-DRAIN aborts the switch and re-samples the strap.
- A CTRL write in the SWITCH cycle is acted upon in the next ACTIVE cycle.

## Configuration
- `MPC_SWITCH_CNT_EN` defined: SWCNT register and counter present.
- Undefined: no counter flops; offset 2 reads 0.

## Structure
- Package `mpc_pkg`: register offsets, STATUS bit positions, FSM state enum, SWCNT width.
- Sub-module `mpc_wb_regs`: Wishbone decode, ack, CTRL/STATUS/SWCNT storage. The top holds the FSM and datapath.

## Test plan
- Strap `configuration`=2, release reset → cur_sel=2; `IO_o` follows `proj_o[2]` one cycle later; `proj_rst_o`=4'b1011.
- Write CTRL=0x8000_0001 with GUARD=4 → busy for 5 cycles, `IO_oe`=0 during DRAIN, then project 1 on pads; SWCNT=1.
- Write req_sel=5 (N_PROJ=4) → err=1, cur_sel unchanged; then write STATUS → err=0.
- During DRAIN write req_sel=3, then req_sel=0 → single switch to 0, SWCNT +1 only.
- Write CTRL with enable=0 → `IO_oe`=0, `proj_rst_o`=4'b1111; re-enable restores selected project.
- Assert `wb_rst_i` mid-DRAIN with strap=3 → state ACTIVE, cur_sel=3, SWCNT=0, ack low.
